// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the 4-point FFT engine:
//     FFT_WIDTH   default signed sample width per real/imag component
//     FFT_POINTS  transform length
//     fft_state_e engine sequencing states
//     is_busy()   decode of the states in which a transform is in flight
//   The width-dependent complex types are declared in the top module, where
//   the WIDTH parameter is known.
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int FFT_WIDTH  = 8;
    localparam int FFT_POINTS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STG1 = 2'd1,
        STG2 = 2'd2,
        DONE = 2'd3
    } fft_state_e;

    function automatic logic is_busy(input fft_state_e s);
        return (s == STG1) || (s == STG2);
    endfunction

endpackage

// File: rtl/fft_bfly2.sv
// ---------------------------------------------------------------------------
// fft_bfly2
//   Combinational radix-2 butterfly on one pair of complex operands.
//   Both operands are sign-extended by one bit before add/sub, so the
//   results carry full growth and can never wrap.
// Ports
//   a_re, a_im   in   IW     signed operand a
//   b_re, b_im   in   IW     signed operand b
//   sum_re/im    out  IW+1   a + b
//   dif_re/im    out  IW+1   a - b
// ---------------------------------------------------------------------------
module fft_bfly2 #(
    parameter int IW = 8
) (
    input  logic signed [IW-1:0] a_re,
    input  logic signed [IW-1:0] a_im,
    input  logic signed [IW-1:0] b_re,
    input  logic signed [IW-1:0] b_im,
    output logic signed [IW:0]   sum_re,
    output logic signed [IW:0]   sum_im,
    output logic signed [IW:0]   dif_re,
    output logic signed [IW:0]   dif_im
);

    logic signed [IW:0] a_re_x;
    logic signed [IW:0] a_im_x;
    logic signed [IW:0] b_re_x;
    logic signed [IW:0] b_im_x;

    assign a_re_x = {a_re[IW-1], a_re};
    assign a_im_x = {a_im[IW-1], a_im};
    assign b_re_x = {b_re[IW-1], b_re};
    assign b_im_x = {b_im[IW-1], b_im};

    assign sum_re = a_re_x + b_re_x;
    assign sum_im = a_im_x + b_im_x;
    assign dif_re = a_re_x - b_re_x;
    assign dif_im = a_im_x - b_im_x;

endmodule

// File: rtl/fft4_engine.sv
// ---------------------------------------------------------------------------
// fft4_engine
//   4-point radix-2 DIT FFT. A start pulse snapshots four complex samples;
//   two registered butterfly stages produce X[0..3] in natural order, which
//   are held with a one-cycle done strobe. Twiddles are only 1 and -j, so
//   the datapath is adders and negation only.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 clock enable; low freezes every register
//   start               begin a transform (honoured only in IDLE or DONE)
//   in{0..3}_re/_im     WIDTH-bit signed samples x[0..3]
//   busy                high while the two butterfly stages run
//   done                high for one enabled cycle when outputs update
//   out{0..3}_re/_im    OWIDTH-bit signed results X[0..3], held until next done
// ---------------------------------------------------------------------------
module fft4_engine
    import fft_pkg::*;
#(
    parameter  int WIDTH  = FFT_WIDTH,
    localparam int OWIDTH = WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     start,
    input  logic signed [WIDTH-1:0]  in0_re,
    input  logic signed [WIDTH-1:0]  in0_im,
    input  logic signed [WIDTH-1:0]  in1_re,
    input  logic signed [WIDTH-1:0]  in1_im,
    input  logic signed [WIDTH-1:0]  in2_re,
    input  logic signed [WIDTH-1:0]  in2_im,
    input  logic signed [WIDTH-1:0]  in3_re,
    input  logic signed [WIDTH-1:0]  in3_im,
    output logic                     busy,
    output logic                     done,
    output logic signed [OWIDTH-1:0] out0_re,
    output logic signed [OWIDTH-1:0] out0_im,
    output logic signed [OWIDTH-1:0] out1_re,
    output logic signed [OWIDTH-1:0] out1_im,
    output logic signed [OWIDTH-1:0] out2_re,
    output logic signed [OWIDTH-1:0] out2_im,
    output logic signed [OWIDTH-1:0] out3_re,
    output logic signed [OWIDTH-1:0] out3_im
);

    localparam int SW = WIDTH + 1;  // stage-1 result width

    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } cplx_in_t;

    typedef struct packed {
        logic signed [SW-1:0] re;
        logic signed [SW-1:0] im;
    } cplx_s1_t;

    typedef struct packed {
        logic signed [OWIDTH-1:0] re;
        logic signed [OWIDTH-1:0] im;
    } cplx_out_t;

    fft_state_e state_q;
    fft_state_e state_d;

    cplx_in_t  x_q [FFT_POINTS];
    cplx_s1_t  a_q [FFT_POINTS];
    cplx_out_t y_q [FFT_POINTS];

    logic x_load;
    logic a_load;
    logic y_load;

    // ------------------------------------------------------------------
    // Sequencing
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: next state defaults to the current state before any branch,
        // so every path assigns it and no latch is inferred.
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                IDLE, DONE: state_d = start ? STG1 : IDLE;
                STG1:       state_d = STG2;
                STG2:       state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state_q <= state_d;
        end
    end

    assign x_load = ena && start && ((state_q == IDLE) || (state_q == DONE));
    assign a_load = ena && (state_q == STG1);
    assign y_load = ena && (state_q == STG2);

    assign busy = is_busy(state_q);
    assign done = (state_q == DONE);

    // ------------------------------------------------------------------
    // Stage 1: a0 = x0 + x2, a1 = x0 - x2, a2 = x1 + x3, a3 = x1 - x3
    // ------------------------------------------------------------------
    logic signed [SW-1:0] a0_re_d, a0_im_d, a1_re_d, a1_im_d;
    logic signed [SW-1:0] a2_re_d, a2_im_d, a3_re_d, a3_im_d;

    fft_bfly2 #(.IW(WIDTH)) u_s1_even (
        .a_re   (x_q[0].re),
        .a_im   (x_q[0].im),
        .b_re   (x_q[2].re),
        .b_im   (x_q[2].im),
        .sum_re (a0_re_d),
        .sum_im (a0_im_d),
        .dif_re (a1_re_d),
        .dif_im (a1_im_d)
    );

    fft_bfly2 #(.IW(WIDTH)) u_s1_odd (
        .a_re   (x_q[1].re),
        .a_im   (x_q[1].im),
        .b_re   (x_q[3].re),
        .b_im   (x_q[3].im),
        .sum_re (a2_re_d),
        .sum_im (a2_im_d),
        .dif_re (a3_re_d),
        .dif_im (a3_im_d)
    );

    // ------------------------------------------------------------------
    // Stage 2: X0 = a0 + a2, X2 = a0 - a2, X1/X3 = a1 +/- (-j * a3)
    // ------------------------------------------------------------------
    // a3 is a difference of two WIDTH-bit values, so its range is symmetric
    // (never the SW-bit minimum) and negating it at SW bits cannot wrap.
    logic signed [SW-1:0] rot_re;
    logic signed [SW-1:0] rot_im;

    assign rot_re = a_q[3].im;
    assign rot_im = -a_q[3].re;

    logic signed [OWIDTH-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
    logic signed [OWIDTH-1:0] y2_re_d, y2_im_d, y3_re_d, y3_im_d;

    fft_bfly2 #(.IW(SW)) u_s2_even (
        .a_re   (a_q[0].re),
        .a_im   (a_q[0].im),
        .b_re   (a_q[2].re),
        .b_im   (a_q[2].im),
        .sum_re (y0_re_d),
        .sum_im (y0_im_d),
        .dif_re (y2_re_d),
        .dif_im (y2_im_d)
    );

    fft_bfly2 #(.IW(SW)) u_s2_odd (
        .a_re   (a_q[1].re),
        .a_im   (a_q[1].im),
        .b_re   (rot_re),
        .b_im   (rot_im),
        .sum_re (y1_re_d),
        .sum_im (y1_im_d),
        .dif_re (y3_re_d),
        .dif_im (y3_im_d)
    );

    // ------------------------------------------------------------------
    // Data registers
    // ------------------------------------------------------------------
    // NOTE: these small register arrays are flops, not RAM, so they take the
    // asynchronous reset; results read back as zero after any reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FFT_POINTS; k++) begin
                x_q[k] <= '0;
                a_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            if (x_load) begin
                x_q[0] <= '{re: in0_re, im: in0_im};
                x_q[1] <= '{re: in1_re, im: in1_im};
                x_q[2] <= '{re: in2_re, im: in2_im};
                x_q[3] <= '{re: in3_re, im: in3_im};
            end
            if (a_load) begin
                a_q[0] <= '{re: a0_re_d, im: a0_im_d};
                a_q[1] <= '{re: a1_re_d, im: a1_im_d};
                a_q[2] <= '{re: a2_re_d, im: a2_im_d};
                a_q[3] <= '{re: a3_re_d, im: a3_im_d};
            end
            if (y_load) begin
                y_q[0] <= '{re: y0_re_d, im: y0_im_d};
                y_q[1] <= '{re: y1_re_d, im: y1_im_d};
                y_q[2] <= '{re: y2_re_d, im: y2_im_d};
                y_q[3] <= '{re: y3_re_d, im: y3_im_d};
            end
        end
    end

    assign out0_re = y_q[0].re;
    assign out0_im = y_q[0].im;
    assign out1_re = y_q[1].re;
    assign out1_im = y_q[1].im;
    assign out2_re = y_q[2].re;
    assign out2_im = y_q[2].im;
    assign out3_re = y_q[3].re;
    assign out3_im = y_q[3].im;

endmodule

// File: tb/tb_fft4_engine.sv
// ---------------------------------------------------------------------------
// tb_fft4_engine
//   Self-checking bench for fft4_engine. Expected results come from a direct
//   4-point DFT using powers of W = -j on integer samples.
// ---------------------------------------------------------------------------
module tb_fft4_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic start;
    logic signed [7:0] in0_re, in0_im, in1_re, in1_im;
    logic signed [7:0] in2_re, in2_im, in3_re, in3_im;
    logic busy;
    logic done;
    logic signed [9:0] out0_re, out0_im, out1_re, out1_im;
    logic signed [9:0] out2_re, out2_im, out3_re, out3_im;

    logic signed [9:0] act_re [4];
    logic signed [9:0] act_im [4];

    int xr [4];
    int xi [4];
    int er [4];
    int ei [4];
    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fft4_engine #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .in0_re  (in0_re),
        .in0_im  (in0_im),
        .in1_re  (in1_re),
        .in1_im  (in1_im),
        .in2_re  (in2_re),
        .in2_im  (in2_im),
        .in3_re  (in3_re),
        .in3_im  (in3_im),
        .busy    (busy),
        .done    (done),
        .out0_re (out0_re),
        .out0_im (out0_im),
        .out1_re (out1_re),
        .out1_im (out1_im),
        .out2_re (out2_re),
        .out2_im (out2_im),
        .out3_re (out3_re),
        .out3_im (out3_im)
    );

    assign act_re[0] = out0_re;
    assign act_im[0] = out0_im;
    assign act_re[1] = out1_re;
    assign act_im[1] = out1_im;
    assign act_re[2] = out2_re;
    assign act_im[2] = out2_im;
    assign act_re[3] = out3_re;
    assign act_im[3] = out3_im;

    // Reference: X[k] = sum_n x[n] * (-j)^(n*k)
    function automatic void dft4(input int ar[4], input int ai[4],
                                 output int yr[4], output int yi[4]);
        for (int k = 0; k < 4; k++) begin
            yr[k] = 0;
            yi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                case ((n * k) % 4)
                    0: begin yr[k] += ar[n]; yi[k] += ai[n]; end
                    1: begin yr[k] += ai[n]; yi[k] -= ar[n]; end  // * -j
                    2: begin yr[k] -= ar[n]; yi[k] -= ai[n]; end  // * -1
                    default: begin yr[k] -= ai[n]; yi[k] += ar[n]; end  // * +j
                endcase
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_x();
        in0_re = xr[0][7:0]; in0_im = xi[0][7:0];
        in1_re = xr[1][7:0]; in1_im = xi[1][7:0];
        in2_re = xr[2][7:0]; in2_im = xi[2][7:0];
        in3_re = xr[3][7:0]; in3_im = xi[3][7:0];
    endtask

    task automatic scramble_inputs();
        in0_re = 8'($urandom); in0_im = 8'($urandom);
        in1_re = 8'($urandom); in1_im = 8'($urandom);
        in2_re = 8'($urandom); in2_im = 8'($urandom);
        in3_re = 8'($urandom); in3_im = 8'($urandom);
    endtask

    task automatic randomize_x();
        for (int n = 0; n < 4; n++) begin
            xr[n] = int'($urandom_range(0, 255)) - 128;
            xi[n] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Pulses start with xr/xi, then counts edges until done (bounded).
    // lat = edges after the accepting edge; busy_cycles = busy samples seen.
    task automatic run_transform(output int lat, output int busy_cycles);
        drive_x();
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_inputs();
        dft4(xr, xi, er, ei);
        lat = 0;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat, bc;
        rst_n = 1'b0; ena = 1'b1; start = 1'b0;
        xr = '{0, 0, 0, 0}; xi = '{0, 0, 0, 0};
        drive_x();
        tick(); tick();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_flags: busy=%0b done=%0b required 0 0", busy, done);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        // Load non-zero results, then reset in the middle of the next transform.
        randomize_x();
        xr[0] = 5;
        run_transform(lat, bc);
        drive_x();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total_cnt++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL reset_pre_stg2: busy=%0b done=%0b required 1 0", busy, done);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_async_flags: busy=%0b done=%0b required 0 0", busy, done);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'sd0 || act_im[k] !== 10'sd0)
                $display("FAIL reset_outputs X%0d: got (%0d,%0d) required (0,0)", k, act_re[k], act_im[k]);
            else pass_cnt++;
        end
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_release_idle: busy=%0b done=%0b required 0 0", busy, done);
        else pass_cnt++;
        xr = '{3, -7, 20, 1}; xi = '{-4, 9, 0, -2};
        run_transform(lat, bc);
        total_cnt++;
        if (lat !== 2) $display("FAIL reset_restart_latency: got %0d required 2", lat);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(er[k]) || act_im[k] !== 10'(ei[k]))
                $display("FAIL reset_restart X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], er[k], ei[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_impulse();
        int lat, bc;
        xr = '{1, 0, 0, 0}; xi = '{0, 0, 0, 0};
        run_transform(lat, bc);
        total_cnt++;
        if (lat !== 2) $display("FAIL impulse_latency: got %0d required 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 2 || busy !== 1'b0)
            $display("FAIL impulse_busy: cycles=%0d busy_at_done=%0b required 2 0", bc, busy);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'sd1 || act_im[k] !== 10'sd0 || er[k] !== 1 || ei[k] !== 0)
                $display("FAIL impulse X%0d: got (%0d,%0d) required (1,0)", k, act_re[k], act_im[k]);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (done !== 1'b0 || act_re[0] !== 10'sd1)
            $display("FAIL impulse_done_strobe: done=%0b X0.re=%0d required 0 1", done, act_re[0]);
        else pass_cnt++;
    endtask

    task automatic test_shifted_impulse();
        int lat, bc;
        int req_re [4] = '{1, 0, -1, 0};
        int req_im [4] = '{0, -1, 0, 1};
        xr = '{0, 1, 0, 0}; xi = '{0, 0, 0, 0};
        run_transform(lat, bc);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(req_re[k]) || act_im[k] !== 10'(req_im[k]))
                $display("FAIL shifted X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], req_re[k], req_im[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_extremes();
        int lat, bc;
        int req_re [4];
        int req_im [4];
        xr = '{-128, -128, -128, -128}; xi = '{-128, -128, -128, -128};
        req_re = '{-512, 0, 0, 0}; req_im = '{-512, 0, 0, 0};
        run_transform(lat, bc);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(req_re[k]) || act_im[k] !== 10'(req_im[k]))
                $display("FAIL extreme_min X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], req_re[k], req_im[k]);
            else pass_cnt++;
        end
        xr = '{127, -128, 127, -128}; xi = '{0, 0, 0, 0};
        req_re = '{-2, 0, 510, 0}; req_im = '{0, 0, 0, 0};
        run_transform(lat, bc);
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(req_re[k]) || act_im[k] !== 10'(req_im[k]))
                $display("FAIL extreme_alt X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], req_re[k], req_im[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat, bc;
        for (int t = 0; t < 25; t++) begin
            randomize_x();
            run_transform(lat, bc);
            total_cnt++;
            if (lat !== 2) $display("FAIL random_latency[%0d]: got %0d required 2", t, lat);
            else pass_cnt++;
            for (int k = 0; k < 4; k++) begin
                total_cnt++;
                if (act_re[k] !== 10'(er[k]) || act_im[k] !== 10'(ei[k]))
                    $display("FAIL random[%0d] X%0d: got (%0d,%0d) required (%0d,%0d)", t, k, act_re[k], act_im[k], er[k], ei[k]);
                else pass_cnt++;
            end
            if (t % 3 == 0) tick();  // mix IDLE and DONE starts
        end
    endtask

    task automatic test_handshake();
        randomize_x();
        dft4(xr, xi, er, ei);
        drive_x();
        start = 1'b1;
        tick();              // accepted, STG1
        scramble_inputs();   // start stays high through STG1 and STG2
        tick();
        tick();
        total_cnt++;
        if (done !== 1'b1) $display("FAIL handshake_done: got %0b required 1", done);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(er[k]) || act_im[k] !== 10'(ei[k]))
                $display("FAIL handshake X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], er[k], ei[k]);
            else pass_cnt++;
        end
        start = 1'b0;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0 || act_re[0] !== 10'(er[0]))
            $display("FAIL handshake_idle: done=%0b busy=%0b X0.re=%0d required 0 0 %0d", done, busy, act_re[0], er[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        int old_re [4];
        int old_im [4];
        randomize_x();
        run_transform(lat, bc);
        old_re = er; old_im = ei;
        randomize_x();
        dft4(xr, xi, er, ei);
        drive_x();
        start = 1'b1;
        tick();              // restart from DONE
        start = 1'b0;
        scramble_inputs();
        for (int c = 0; c < 2; c++) begin
            total_cnt++;
            if (done !== 1'b0 || busy !== 1'b1 || act_re[1] !== 10'(old_re[1]) || act_im[3] !== 10'(old_im[3]))
                $display("FAIL b2b_hold[%0d]: done=%0b busy=%0b X1.re=%0d X3.im=%0d required 0 1 %0d %0d", c, done, busy, act_re[1], act_im[3], old_re[1], old_im[3]);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (done !== 1'b1) $display("FAIL b2b_done: got %0b required 1", done);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(er[k]) || act_im[k] !== 10'(ei[k]))
                $display("FAIL b2b X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], er[k], ei[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ena();
        int lat;
        randomize_x();
        dft4(xr, xi, er, ei);
        drive_x();
        start = 1'b1;
        tick();
        start = 1'b0;
        ena = 1'b0;
        for (int c = 0; c < 4; c++) begin
            scramble_inputs();
            tick();
            total_cnt++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL ena_stall[%0d]: busy=%0b done=%0b required 1 0", c, busy, done);
            else pass_cnt++;
        end
        ena = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        total_cnt++;
        if (lat !== 2) $display("FAIL ena_resume_latency: got %0d required 2", lat);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (act_re[k] !== 10'(er[k]) || act_im[k] !== 10'(ei[k]))
                $display("FAIL ena X%0d: got (%0d,%0d) required (%0d,%0d)", k, act_re[k], act_im[k], er[k], ei[k]);
            else pass_cnt++;
        end
        ena = 1'b0;
        start = 1'b1;        // must not be taken while disabled
        for (int c = 0; c < 3; c++) begin
            scramble_inputs();
            tick();
            total_cnt++;
            if (done !== 1'b1 || busy !== 1'b0 || act_re[2] !== 10'(er[2]) || act_im[0] !== 10'(ei[0]))
                $display("FAIL ena_done_hold[%0d]: done=%0b busy=%0b X2.re=%0d X0.im=%0d required 1 0 %0d %0d", c, done, busy, act_re[2], act_im[0], er[2], ei[0]);
            else pass_cnt++;
        end
        start = 1'b0;
        ena = 1'b1;
        tick();
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL ena_release: done=%0b busy=%0b required 0 0", done, busy);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_shifted_impulse();
        test_extremes();
        test_random();
        test_handshake();
        test_back_to_back();
        test_ena();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
